// File: rtl/ucounter8_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ucounter8_pkg
// Brief    : Shared width, limit and mode constants for ucounter8 and checkers.
// Revision : 1.0  initial release
// ============================================================================
package ucounter8_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ECNT_W = 8;

    localparam logic [DEF_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [DEF_WIDTH-1:0] CNT_MIN = '0;

    localparam logic MODE_WRAP = 1'b1;
    localparam logic MODE_STOP = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ucounter8_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ucounter8_if
// Brief    : Control and result pins of one ucounter8 instance.
// Revision : 1.0  initial release
// ============================================================================
interface ucounter8_if #(
    parameter int WIDTH = ucounter8_pkg::DEF_WIDTH
);
    logic             _load;
    logic [WIDTH-1:0] preld_val;
    logic             _updown;
    logic             _wrapstop;
    logic [WIDTH-1:0] dcount;
    logic             overflow;

    // master: whatever drives the counter pins; slave: an observer such as the monitor
    modport master (
        output _load, preld_val, _updown, _wrapstop, dcount, overflow
    );
    modport slave (
        input  _load, preld_val, _updown, _wrapstop, dcount, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ucounter8_model.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ucounter8_model
// Brief    : Cycle-exact golden model of the ucounter8 count and overflow.
// Revision : 1.0  initial release
// ============================================================================
module ucounter8_model
    import ucounter8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             _areset,
    input  wire logic             _aset,
    input  wire logic             _load,
    input  wire logic [WIDTH-1:0] preld_val,
    input  wire logic             _updown,
    input  wire logic             _wrapstop,
    output logic      [WIDTH-1:0] count_o,
    output logic                  ovf_o
);

    localparam logic [WIDTH-1:0] C_MAX = '1;
    localparam logic [WIDTH-1:0] C_MIN = '0;
    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // Pushing against a limit flags overflow every cycle, whether it wraps or holds
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (!_load) begin
            count_d = preld_val;
        end else if (_updown == DIR_UP) begin
            if (count_q == C_MAX) begin
                ovf_d = 1'b1;
                if (_wrapstop == MODE_WRAP) count_d = C_MIN;
            end else begin
                count_d = count_q + C_ONE;
            end
        end else begin
            if (count_q == C_MIN) begin
                ovf_d = 1'b1;
                if (_wrapstop == MODE_WRAP) count_d = C_MAX;
            end else begin
                count_d = count_q - C_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge _areset or negedge _aset) begin
        if (!_areset) begin
            count_q <= C_MIN;
            ovf_q   <= 1'b0;
        end else if (!_aset) begin
            count_q <= C_MAX;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/ucounter8_mon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ucounter8_mon
// Brief    : On-line checker comparing a ucounter8 against a shadow model.
// Revision : 1.0  initial release
// ============================================================================
module ucounter8_mon
    import ucounter8_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ECNT_W = DEF_ECNT_W
) (
    input  wire logic              clk,
    input  wire logic              _areset,
    input  wire logic              _aset,
    input  wire logic              err_clr,
    ucounter8_if.slave             mon,
    output logic                   chk_valid,
    output logic                   err,
    output logic      [ECNT_W-1:0] err_cnt,
    output logic      [WIDTH-1:0]  first_exp,
    output logic      [WIDTH-1:0]  first_got
);

    localparam logic [ECNT_W-1:0] C_ECNT_MAX = '1;
    localparam logic [ECNT_W-1:0] C_ECNT_ONE = {{(ECNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  shadow;
    logic              shadow_ovf;
    logic              mismatch;

    logic              chk_valid_q;
    logic              err_q, err_d;
    logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]  first_exp_q, first_exp_d;
    logic [WIDTH-1:0]  first_got_q, first_got_d;

    ucounter8_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .clk       (clk),
        ._areset   (_areset),
        ._aset     (_aset),
        ._load     (mon._load),
        .preld_val (mon.preld_val),
        ._updown   (mon._updown),
        ._wrapstop (mon._wrapstop),
        .count_o   (shadow),
        .ovf_o     (shadow_ovf)
    );

    // Shadow values here are the pre-edge ones, aligned with what the DUT shows now
    assign mismatch = chk_valid_q &&
                      ((mon.dcount != shadow) || (mon.overflow != shadow_ovf));

    always_comb begin
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        if (err_clr) begin
            err_d       = 1'b0;
            err_cnt_d   = '0;
            first_exp_d = '0;
            first_got_d = '0;
        end else if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != C_ECNT_MAX) err_cnt_d = err_cnt_q + C_ECNT_ONE;
            if (!err_q) begin
                first_exp_d = shadow;
                first_got_d = mon.dcount;
            end
        end
    end

    // _aset deliberately leaves checking armed: both sides are forced to all ones
    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            chk_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            chk_valid_q <= 1'b1;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    assign chk_valid = chk_valid_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign first_exp = first_exp_q;
    assign first_got = first_got_q;

endmodule
`default_nettype wire

// File: tb/tb_ucounter8_mon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ucounter8_mon
// Brief    : Self-checking bench: directed vector table plus randomized model run.
// Revision : 1.0  initial release
// ============================================================================
module tb_ucounter8_mon;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       areset_n, aset_n, err_clr;
    logic       load_n, up, wrap, ov;
    logic [7:0] preld, dc;

    logic       chk_valid, err;
    logic [7:0] err_cnt, first_exp, first_got;

    ucounter8_if #(.WIDTH(8)) bus ();
    assign bus._load     = load_n;
    assign bus.preld_val = preld;
    assign bus._updown   = up;
    assign bus._wrapstop = wrap;
    assign bus.dcount    = dc;
    assign bus.overflow  = ov;

    ucounter8_mon #(.WIDTH(8), .ECNT_W(8)) dut (
        .clk       (clk),
        ._areset   (areset_n),
        ._aset     (aset_n),
        .err_clr   (err_clr),
        .mon       (bus),
        .chk_valid (chk_valid),
        .err       (err),
        .err_cnt   (err_cnt),
        .first_exp (first_exp),
        .first_got (first_got)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: an ideal counter plus the error bookkeeping it implies
    int m_cnt, m_fexp, m_fgot, m_ecnt;
    bit m_ovf, m_valid, m_err;

    typedef struct {
        bit         ld_n;
        logic [7:0] pv;
        bit         u;
        bit         w;
        logic [7:0] d;
        bit         o;
        bit         e_err;
        logic [7:0] e_cnt;
        logic [7:0] e_fexp;
        logic [7:0] e_fgot;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(bit ld_n, logic [7:0] pv, bit u, bit w, logic [7:0] d, bit o,
                                bit ee, logic [7:0] ec, logic [7:0] fe, logic [7:0] fg);
        vec_t v;
        v.ld_n = ld_n; v.pv = pv; v.u = u; v.w = w; v.d = d; v.o = o;
        v.e_err = ee; v.e_cnt = ec; v.e_fexp = fe; v.e_fgot = fg;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ovf = 0; m_valid = 0; m_err = 0; m_ecnt = 0; m_fexp = 0; m_fgot = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".chk_valid"}, int'(chk_valid), int'(m_valid));
        chk({tag, ".err"},       int'(err),       int'(m_err));
        chk({tag, ".err_cnt"},   int'(err_cnt),   m_ecnt);
        chk({tag, ".first_exp"}, int'(first_exp), m_fexp);
        chk({tag, ".first_got"}, int'(first_got), m_fgot);
    endtask

    // Advance the reference by one clock edge using the inputs currently applied
    task automatic step_model();
        bit mism;
        bit at_limit;
        mism = m_valid && ((int'(dc) != m_cnt) || (ov != m_ovf));
        if (err_clr) begin
            m_err = 0; m_ecnt = 0; m_fexp = 0; m_fgot = 0;
        end else if (mism) begin
            if (!m_err) begin
                m_fexp = m_cnt;
                m_fgot = int'(dc);
            end
            m_err = 1;
            if (m_ecnt < 255) m_ecnt++;
        end
        if (!aset_n) begin
            m_cnt = 255; m_ovf = 0;
        end else if (!load_n) begin
            m_cnt = int'(preld); m_ovf = 0;
        end else begin
            at_limit = up ? (m_cnt == 255) : (m_cnt == 0);
            if (at_limit) begin
                m_ovf = 1;
                if (wrap) m_cnt = up ? 0 : 255;
            end else begin
                m_ovf = 0;
                m_cnt = up ? (m_cnt + 1) % 256 : (m_cnt + 255) % 256;
            end
        end
        m_valid = 1;
    endtask

    // Called 1ns after a rising edge; returns 1ns after the next one
    task automatic cycle(input bit drive_ok, input string tag);
        if (drive_ok) begin
            dc = 8'(m_cnt);
            ov = m_ovf;
        end
        step_model();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic aset_pulse();
        aset_n = 1'b0;
        #2;
        m_cnt = 255; m_ovf = 0;
        aset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        tbl[0]  = mk(0, 8'hF8, 1, 1, 8'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8'h00, 1, 1, 8'hF8, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 8'h00, 1, 1, 8'hF9, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 8'h00, 1, 1, 8'hFA, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 8'h00, 1, 1, 8'hFB, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 8'h00, 1, 1, 8'hFC, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 8'h00, 1, 1, 8'hFD, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 8'h00, 1, 1, 8'hFE, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 8'h00, 1, 1, 8'hFF, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 8'h00, 1, 1, 8'h00, 1, 0, 0, 0, 0);
        tbl[10] = mk(1, 8'h00, 1, 1, 8'h01, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 8'h02, 0, 0, 8'h02, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 8'h00, 0, 0, 8'h02, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 8'h00, 0, 0, 8'h01, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        tbl[16] = mk(1, 8'h00, 0, 0, 8'hFF, 1, 1, 8'd1, 8'h00, 8'hFF);

        areset_n = 1'b0; aset_n = 1'b1; err_clr = 1'b0;
        load_n = 1'b1; preld = 8'h00; up = 1'b1; wrap = 1'b1; dc = 8'h00; ov = 1'b0;
        #1;
        chk("reset.chk_valid", int'(chk_valid), 0);
        chk("reset.err",       int'(err),       0);
        chk("reset.err_cnt",   int'(err_cnt),   0);
        chk("reset.first_exp", int'(first_exp), 0);
        chk("reset.first_got", int'(first_got), 0);
        repeat (2) @(posedge clk);
        #3;
        areset_n = 1'b1;

        // Directed table: dcount/overflow hold the hand-derived pre-edge shadow
        for (int i = 0; i < 17; i++) begin
            load_n = tbl[i].ld_n; preld = tbl[i].pv; up = tbl[i].u; wrap = tbl[i].w;
            dc = tbl[i].d; ov = tbl[i].o;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.chk_valid", i), int'(chk_valid), 1);
            chk($sformatf("tbl%0d.err", i),       int'(err),       int'(tbl[i].e_err));
            chk($sformatf("tbl%0d.err_cnt", i),   int'(err_cnt),   int'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.first_exp", i), int'(first_exp), int'(tbl[i].e_fexp));
            chk($sformatf("tbl%0d.first_got", i), int'(first_got), int'(tbl[i].e_fgot));
        end

        // Mid-run async reset: everything drops without waiting for a clock
        areset_n = 1'b0;
        #1;
        chk("areset.chk_valid", int'(chk_valid), 0);
        chk("areset.err",       int'(err),       0);
        chk("areset.err_cnt",   int'(err_cnt),   0);
        chk("areset.first_exp", int'(first_exp), 0);
        chk("areset.first_got", int'(first_got), 0);
        model_reset();
        #2;
        areset_n = 1'b1;
        load_n = 1'b1; up = 1'b1; wrap = 1'b1;
        cycle(1, "rearm");

        // Randomized run with occasional faults, clears, loads and async sets
        for (int n = 0; n < 300; n++) begin
            load_n = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 4);
            preld = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : (r == 2) ? 8'hFE :
                    (r == 3) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 7) == 0) up = ~up;
            if ($urandom_range(0, 7) == 0) wrap = ~wrap;
            err_clr = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 15);
            if (r == 2) aset_pulse();
            dc = 8'(m_cnt);
            ov = m_ovf;
            if (r == 0) dc = dc ^ 8'($urandom_range(1, 255));
            else if (r == 1) ov = ~ov;
            cycle(0, "rand");
        end

        // Clear wins over a simultaneous mismatch
        err_clr = 1'b1; load_n = 1'b1;
        dc = 8'(m_cnt) ^ 8'h5A; ov = m_ovf;
        cycle(0, "clr_wins");
        chk("clr_wins.err_const", int'(err), 0);
        err_clr = 1'b0;

        // dcount stuck at 05: error count must saturate, capture stays on first event
        up = 1'b1; wrap = 1'b1;
        for (int n = 0; n < 300; n++) begin
            dc = 8'h05; ov = 1'b0;
            cycle(0, "stuck");
        end
        chk("stuck.err_cnt_sat", int'(err_cnt), 255);

        // err_clr pulse then a correct counter
        err_clr = 1'b1;
        cycle(1, "errclr");
        err_clr = 1'b0;
        for (int n = 0; n < 5; n++) cycle(1, "post_clr");
        chk("post_clr.err_const", int'(err), 0);

        // Async set held across edges, then wrap out of all ones
        aset_n = 1'b0;
        #2;
        m_cnt = 255; m_ovf = 0;
        cycle(1, "aset_low");
        cycle(1, "aset_low2");
        aset_n = 1'b1;
        cycle(1, "aset_rel");
        chk("aset_rel.exp_ovf", int'(m_ovf), 1);
        dc = 8'h00; ov = 1'b1;
        cycle(0, "aset_wrap");
        chk("aset_wrap.err_const", int'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ucounter8_mon.md
Name: ucounter8_mon

Overview:
- Synthesizable on-line checker that sits on the output side of the ucounter8 up/down counter interface.
- Watches the same control pins the counter receives, plus the counter's dcount/overflow results.
- Runs a cycle-exact shadow model of the counter and flags any mismatch, with sticky error, saturating error count and first-failure capture.
- Placed beside any ucounter8 instance, in silicon or in a bench, so we can run self-checking without hand-built expected waveforms.

Parameters:
- WIDTH, 8, counter/data width; the shadow model, preld_val and dcount all use it.
- ECNT_W, 8, width of the error counter.

Ports:
- clk  input  1  counter clock, shared with the monitored ucounter8.
- _areset  input  1  asynchronous active-low reset; clears the monitor and models the counter's reset.
- _aset  input  1  copy of the counter's async active-low set.
- _load  input  1  copy of counter load, active-low, synchronous.
- preld_val  input  WIDTH  copy of counter preload value.
- _updown  input  1  copy of counter direction; 1 = up, 0 = down.
- _wrapstop  input  1  copy of counter mode; 1 = wrap, 0 = stop at limit.
- dcount  input  WIDTH  counter output under check.
- overflow  input  1  counter overflow under check.
- err_clr  input  1  synchronous active-high clear of err/err_cnt/capture.
- chk_valid  output  1  comparisons are armed.
- err  output  1  sticky mismatch flag.
- err_cnt  output  ECNT_W  number of mismatching cycles, saturating.
- first_exp  output  WIDTH  shadow count at the first mismatch.
- first_got  output  WIDTH  dcount at the first mismatch.

Behaviour:
- Reset (_areset low, async): shadow=0, shadow_ovf=0, chk_valid=0, err=0, err_cnt=0, first_exp=0, first_got=0.
- Shadow model priority, highest first:
  - _areset low -> shadow=0 (async).
  - _aset low -> shadow=all ones (async); shadow_ovf=0.
  - _load low at posedge -> shadow=preld_val; shadow_ovf=0.
  - Otherwise count at posedge:
    - Up at all-ones with wrap -> 0, shadow_ovf=1.
    - Up at all-ones with stop -> hold, shadow_ovf=1.
    - Down at 0 with wrap -> all-ones, shadow_ovf=1.
    - Down at 0 with stop -> hold, shadow_ovf=1.
    - Any other case -> +1 or -1 modulo 2^WIDTH, shadow_ovf=0.
- overflow is registered and lasts exactly one cycle per boundary event; holding at the stop limit re-asserts it every cycle the count is pushed against the limit.
- Arming: chk_valid rises on the first posedge after _areset is released. It stays high while _aset is low, because both sides are forced asynchronously to the same value.
- Compare: at each posedge with chk_valid=1, sample dcount/overflow and compare them with shadow/shadow_ovf as they were before that edge's update. Latency from DUT divergence to err=1 is 1 clock.
- On mismatch:
  - err is set and sticky.
  - err_cnt increments, saturating at 2^ECNT_W-1.
  - first_exp/first_got are written only when err was 0.
- err_clr at posedge clears err, err_cnt, first_exp and first_got. The shadow model is unaffected. If a mismatch occurs in the same cycle, clear wins and the mismatch is dropped.
- A mid-run _areset drop clears everything immediately. Checking resumes one posedge after release.

Decomposition:
- Shared package ucounter8_pkg holds:
  - WIDTH default;
  - CNT_MAX (all ones) and CNT_MIN (0);
  - mode constants for wrap=1, stop=0, up=1, down=0.
- The real ucounter8 should import the same package.
- One natural sub-module, ucounter8_model: the shadow counter alone (count + overflow), reusable as a golden model elsewhere.
- The monitor wraps ucounter8_model and adds the compare, error counter and capture logic.

Test Plan:
- Release _areset, _load high, up, wrap, DUT correct for 10 clocks -> chk_valid=1 after first edge; err=0; err_cnt=0.
- _load low one cycle with preld_val=8'hF8, then up/wrap for 10 clocks, DUT correct -> shadow F8..FF,00,01; one-cycle shadow_ovf after FF; err stays 0.
- Stop mode, down from 8'h02 for 5 clocks -> shadow 01,00,00,00; overflow expected high on each hold cycle; a DUT that wraps to FF gives err=1, first_exp=00, first_got=FF.
- Force dcount stuck at 8'h05 while shadow counts for 300 clocks -> err=1, err_cnt saturates at 255, first capture unchanged after the first event.
- _aset low mid-count, async -> shadow=FF immediately; DUT FF gives no error; release plus up/wrap -> next 00 with overflow=1.
- err_clr pulse after errors, then a correct DUT for 5 clocks -> err=0, err_cnt=0, capture=0; _areset pulse mid-run -> all outputs 0 asynchronously, chk_valid=1 again one clock after release.
